// File: rtl/node_pkg.sv
// Shared definitions for the sensor-node instruction sequencer.
// Holds the node opcode encodings, the sequencer state encoding and a small
// decode helper telling which opcodes start a real node handshake.
package node_pkg;

    localparam logic [2:0] OP_IDLE         = 3'b000;
    localparam logic [2:0] OP_READ_SENSOR  = 3'b001;
    localparam logic [2:0] OP_READ_RADIO   = 3'b010;
    localparam logic [2:0] OP_WRITE_RADIO  = 3'b011;
    localparam logic [2:0] OP_WRITE_MEMORY = 3'b100;
    localparam logic [2:0] OP_READ_MEMORY  = 3'b101;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;
    localparam logic [2:0] ST_FINISH    = 3'd5;

    // IDLE and the reserved codes 110/111 are skipped without a handshake.
    function automatic logic op_valid(logic [2:0] op);
        return (op != OP_IDLE) && (op <= OP_READ_MEMORY);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Saturating cycle counter shared by the sequencer's wait and gap states.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear to zero (wins over en)
//   en       : count up by one, holding at the all-ones value
//   limit    : compare value
//   hit      : count has reached or passed limit
module seq_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         hit
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign hit = (cnt_q >= limit);

endmodule

// File: rtl/node_sequencer.sv
// Upstream instruction issuer for the sensor node. Stores a small program of
// node opcodes and replays it using the enable/inst/busy handshake, with an
// optional loop, inter-instruction gap and handshake timeouts.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   prog_we/addr/wdata        : program write port (dropped while seq_busy)
//   prog_len                  : entry count, sampled on an accepted start
//   start, loop_en, abort     : run control
//   node_busy                 : busy from the node
//   node_enable, node_inst    : drive to the node
//   seq_busy, cur_idx         : run status
//   done                      : one-cycle pulse on normal completion
//   error                     : sticky timeout flag, cleared by start
module node_sequencer
    import node_pkg::*;
#(
    parameter int unsigned PROG_DEPTH   = 8,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter int unsigned DONE_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [2:0]                    prog_wdata,
    input  logic [$clog2(PROG_DEPTH):0]   prog_len,
    input  logic                          start,
    input  logic                          loop_en,
    input  logic                          abort,
    input  logic                          node_busy,
    output logic                          node_enable,
    output logic [2:0]                    node_inst,
    output logic                          seq_busy,
    output logic [$clog2(PROG_DEPTH)-1:0] cur_idx,
    output logic                          done,
    output logic                          error
);

    localparam int unsigned AW   = $clog2(PROG_DEPTH);
    localparam int unsigned TM0  = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
    localparam int unsigned TMAX = (TM0 > GAP_CYCLES) ? TM0 : GAP_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    // The timer is cleared on state entry, so a limit of N-1 gives N cycles.
    localparam logic [TW-1:0] ACK_LIM  = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] DONE_LIM = TW'(DONE_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LIM  = (GAP_CYCLES == 0) ? '0 : TW'(GAP_CYCLES - 1);

    logic [2:0]    prog [PROG_DEPTH];

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   len_q, len_d;
    logic [2:0]    inst_q, inst_d;
    logic          en_q, en_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          busy_q;

    logic          tmr_clr, tmr_en, tmr_hit, adv;
    logic [TW-1:0] tmr_limit;
    logic [AW:0]   idx_next;
    logic [2:0]    cur_op;

    assign idx_next = {1'b0, idx_q} + (AW+1)'(1);
    assign cur_op   = prog[idx_q];

    // Program store: not reset, and frozen for the duration of a run.
    always_ff @(posedge clk) begin
        if (prog_we && !busy_q) begin
            prog[prog_addr] <= prog_wdata;
        end
    end

    seq_timer #(
        .W(TW)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .limit(tmr_limit),
        .hit  (tmr_hit)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        inst_d    = inst_q;
        en_d      = en_q;
        done_d    = 1'b0;
        err_d     = err_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        tmr_limit = '0;
        adv       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (prog_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d   = prog_len;
                        idx_d   = '0;
                        en_d    = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (op_valid(cur_op)) begin
                    inst_d  = cur_op;
                    tmr_clr = 1'b1;
                    state_d = ST_WAIT_ACK;
                end else begin
                    adv = 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                tmr_limit = ACK_LIM;
                if (node_busy) begin
                    inst_d  = OP_IDLE;
                    tmr_clr = 1'b1;
                    state_d = ST_WAIT_DONE;
                end else if (tmr_hit) begin
                    inst_d  = OP_IDLE;
                    err_d   = 1'b1;
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                tmr_limit = DONE_LIM;
                if (!node_busy) begin
                    if (GAP_CYCLES == 0) begin
                        adv = 1'b1;
                    end else begin
                        tmr_clr = 1'b1;
                        state_d = ST_GAP;
                    end
                end else if (tmr_hit) begin
                    inst_d  = OP_IDLE;
                    err_d   = 1'b1;
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_GAP: begin
                tmr_limit = GAP_LIM;
                if (tmr_hit) begin
                    adv = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                en_d    = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (adv) begin
            if (idx_next < len_q) begin
                idx_d   = idx_next[AW-1:0];
                state_d = ST_ISSUE;
            end else if (loop_en) begin
                idx_d   = '0;
                state_d = ST_ISSUE;
            end else begin
                state_d = ST_FINISH;
            end
        end

        // Abort overrides everything except in IDLE, where start has priority.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            inst_d  = OP_IDLE;
            en_d    = 1'b0;
            done_d  = 1'b0;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            inst_q  <= OP_IDLE;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            inst_q  <= inst_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign node_enable = en_q;
    assign node_inst   = inst_q;
    assign seq_busy    = busy_q;
    assign cur_idx     = idx_q;
    assign done        = done_q;
    assign error       = err_q;

endmodule

// File: tb/tb_node_sequencer.sv
// Self-checking bench for node_sequencer: a behavioural node answers each
// issued opcode and checks it against a scoreboard of expected {opcode, index}
// pairs; table-driven runs plus hand-written timeout/loop/abort/reset cases.
module tb_node_sequencer;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       prog_we;
    logic [2:0] prog_addr;
    logic [2:0] prog_wdata;
    logic [3:0] prog_len;
    logic       start;
    logic       loop_en;
    logic       abort;
    logic       node_busy;
    logic       node_enable;
    logic [2:0] node_inst;
    logic       seq_busy;
    logic [2:0] cur_idx;
    logic       done;
    logic       error;

    node_sequencer #(
        .PROG_DEPTH  (8),
        .GAP_CYCLES  (GAP),
        .ACK_TIMEOUT (16),
        .DONE_TIMEOUT(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .prog_len   (prog_len),
        .start      (start),
        .loop_en    (loop_en),
        .abort      (abort),
        .node_busy  (node_busy),
        .node_enable(node_enable),
        .node_inst  (node_inst),
        .seq_busy   (seq_busy),
        .cur_idx    (cur_idx),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op;
        int idx;
    } exp_t;

    typedef struct {
        logic [7:0][2:0] prog;
        int              len;
        int              exp_hs;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   hs_cnt = 0;
    int   inst_cyc = 0;
    int   node_mode = 0;  // 0: answers handshakes, 1: never raises busy

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic bit is_real_op(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd5);
    endfunction

    // Behavioural node plus output monitor, sampling 1 ns after each edge.
    initial begin
        int cyc = 0;
        int nst = 0;
        int hold = 0;
        int raise_cyc = 0;
        int fall_cyc = -100;
        exp_t e;
        node_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) done_cnt++;
            if (node_inst != 3'b000) inst_cyc++;
            if (nst == 0) begin
                if (node_inst != 3'b000 && node_mode == 0) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_issue", int'(node_inst), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("issue_op", int'(node_inst), e.op);
                        check("issue_idx", int'(cur_idx), e.idx);
                    end
                    check("gap_ok", (cyc - fall_cyc - 1 >= GAP) ? 1 : 0, 1);
                    node_busy = 1'b1;
                    raise_cyc = cyc;
                    hold = 4;
                    nst = 1;
                end
            end else begin
                if (cyc == raise_cyc + 1) check("inst_cleared", int'(node_inst), 0);
                hold--;
                if (hold == 0) begin
                    node_busy = 1'b0;
                    fall_cyc = cyc;
                    nst = 0;
                end
            end
        end
    end

    task automatic load(input logic [7:0][2:0] p);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            prog_we    = 1'b1;
            prog_addr  = 3'(k);
            prog_wdata = p[k];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic start_run(input int len);
        @(negedge clk);
        prog_len = 4'(len);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output int ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > d0 || error) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_hs(input int target, input int budget, output int ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (hs_cnt >= target) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    vec_t vec[6];

    initial begin
        int ok;
        int d0;
        int h0;

        vec[0].prog = {3'd0, 3'd0, 3'd0, 3'b010, 3'b011, 3'b101, 3'b100, 3'b001};
        vec[0].len = 5; vec[0].exp_hs = 5;
        vec[1].prog = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b100, 3'b000, 3'b001};
        vec[1].len = 3; vec[1].exp_hs = 2;
        vec[2].prog = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b011, 3'b111, 3'b110};
        vec[2].len = 3; vec[2].exp_hs = 1;
        vec[3].prog = {3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        vec[3].len = 0; vec[3].exp_hs = 0;
        vec[4].prog = {3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b101, 3'b100, 3'b011};
        vec[4].len = 8; vec[4].exp_hs = 8;
        vec[5].prog = {3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
        vec[5].len = 1; vec[5].exp_hs = 1;

        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; prog_len = '0;
        start = 1'b0; loop_en = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_enable", int'(node_enable), 0);
        check("rst_inst", int'(node_inst), 0);
        check("rst_seq_busy", int'(seq_busy), 0);
        check("rst_cur_idx", int'(cur_idx), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        rst = 1'b0;

        // Node never acknowledges: timeout after 16 WAIT_ACK cycles.
        node_mode = 1;
        load({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b001});
        inst_cyc = 0;
        d0 = done_cnt;
        start_run(1);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (error) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("to_seen", ok, 1);
        check("to_inst_cycles", inst_cyc, 16);
        check("to_inst", int'(node_inst), 0);
        check("to_seq_busy", int'(seq_busy), 0);
        check("to_enable", int'(node_enable), 0);
        repeat (5) @(negedge clk);
        check("to_sticky", int'(error), 1);
        check("to_no_done", done_cnt, d0);
        node_mode = 0;

        // Table-driven runs.
        for (int v = 0; v < 6; v++) begin
            load(vec[v].prog);
            for (int k = 0; k < vec[v].len; k++) begin
                if (is_real_op(vec[v].prog[k])) exp_q.push_back('{int'(vec[v].prog[k]), k});
            end
            d0 = done_cnt;
            h0 = hs_cnt;
            start_run(vec[v].len);
            wait_done(d0, 2000, ok);
            check($sformatf("v%0d_end", v), ok, 1);
            repeat (6) @(negedge clk);
            check($sformatf("v%0d_hs", v), hs_cnt - h0, vec[v].exp_hs);
            check($sformatf("v%0d_done", v), done_cnt - d0, 1);
            check($sformatf("v%0d_error", v), int'(error), 0);
            check($sformatf("v%0d_enable", v), int'(node_enable), 0);
            check($sformatf("v%0d_seq_busy", v), int'(seq_busy), 0);
            check($sformatf("v%0d_sb_empty", v), exp_q.size(), 0);
            exp_q.delete();
        end

        // Loop over {001, 010}, then abort during the fifth WAIT_DONE.
        load({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b010, 3'b001});
        exp_q.push_back('{1, 0});
        exp_q.push_back('{2, 1});
        exp_q.push_back('{1, 0});
        exp_q.push_back('{2, 1});
        exp_q.push_back('{1, 0});
        d0 = done_cnt;
        h0 = hs_cnt;
        loop_en = 1'b1;
        start_run(2);
        wait_hs(h0 + 5, 1000, ok);
        check("loop_hs_seen", ok, 1);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_enable", int'(node_enable), 0);
        check("abort_seq_busy", int'(seq_busy), 0);
        check("abort_inst", int'(node_inst), 0);
        loop_en = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt, d0);
        check("abort_hs", hs_cnt - h0, 5);
        check("abort_error", int'(error), 0);
        check("loop_sb_empty", exp_q.size(), 0);
        exp_q.delete();

        // Program write and start during a run are both dropped.
        load({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b001});
        exp_q.push_back('{1, 0});
        d0 = done_cnt;
        h0 = hs_cnt;
        start_run(1);
        @(negedge clk);
        check("run_seq_busy", int'(seq_busy), 1);
        prog_we = 1'b1; prog_addr = 3'd0; prog_wdata = 3'b101;
        prog_len = 4'd5; start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        wait_done(d0, 2000, ok);
        check("we_run1_end", ok, 1);
        repeat (6) @(negedge clk);
        check("we_run1_hs", hs_cnt - h0, 1);
        check("we_run1_done", done_cnt - d0, 1);
        exp_q.push_back('{1, 0});
        start_run(1);
        wait_done(d0 + 1, 2000, ok);
        check("we_run2_end", ok, 1);
        repeat (6) @(negedge clk);
        check("we_run2_hs", hs_cnt - h0, 2);
        check("we_sb_empty", exp_q.size(), 0);
        exp_q.delete();

        // Asynchronous reset in WAIT_DONE.
        load({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b011});
        exp_q.push_back('{3, 0});
        d0 = done_cnt;
        h0 = hs_cnt;
        start_run(1);
        wait_hs(h0 + 1, 200, ok);
        check("rstmid_hs_seen", ok, 1);
        @(negedge clk);
        check("rstmid_pre_busy", int'(seq_busy), 1);
        rst = 1'b1;
        #1;
        check("rstmid_enable", int'(node_enable), 0);
        check("rstmid_inst", int'(node_inst), 0);
        check("rstmid_seq_busy", int'(seq_busy), 0);
        check("rstmid_cur_idx", int'(cur_idx), 0);
        check("rstmid_done", int'(done), 0);
        check("rstmid_error", int'(error), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rstmid_no_done", done_cnt, d0);
        check("rstmid_idle", int'(seq_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
